// File: rtl/malu_seq.sv
// Sequential matrix ALU: one result element per clock under a start/busy/done handshake.
// Operands, opcode, scalar and active size are latched on an accepted start.
module malu_seq #(
  parameter int DIM = 5,
  parameter int W   = 8,
  parameter int FW  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [3:0]             opcode,
  input  logic [2:0]             size,
  input  logic [FW-1:0]          f,
  input  logic [DIM*DIM*W-1:0]   A_flat,
  input  logic [DIM*DIM*W-1:0]   B_flat,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [DIM*DIM*W-1:0]   C_flat
);

  localparam int unsigned DIMU = DIM;
  localparam int unsigned WU   = W;
  localparam int          IW   = $clog2(DIM);
  localparam int          NW   = $clog2(DIM + 1);
  // Wide enough for any exact result: scalar product or a full mul accumulation.
  localparam int          EW   = 2 * W + FW + 8;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
  typedef enum logic [3:0] {
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_MUL = 4'd3,
    OP_TRN = 4'd4,
    OP_NEG = 4'd5,
    OP_SCL = 4'd6
  } op_e;

  state_e                   state_q, state_d;
  logic [DIM*DIM*W-1:0]     a_q, a_d, b_q, b_d, c_flat_q, c_flat_d;
  logic [3:0]               op_q, op_d;
  logic signed [FW-1:0]     f_q, f_d;
  logic [NW-1:0]            n_q, n_d;
  logic [IW-1:0]            r_q, r_d, c_q, c_d;
  logic                     ovf_q, ovf_d;

  logic signed [W-1:0]      a_rc, b_rc, a_cr, trunc;
  logic signed [EW-1:0]     exact;
  logic                     in_range, ovf_elem;
  int unsigned              ri, ci, ni;

  always_comb begin
    ri       = 32'(r_q);
    ci       = 32'(c_q);
    ni       = 32'(n_q);
    a_rc     = $signed(a_q[(ri * DIMU + ci) * WU +: W]);
    b_rc     = $signed(b_q[(ri * DIMU + ci) * WU +: W]);
    a_cr     = $signed(a_q[(ci * DIMU + ri) * WU +: W]);
    in_range = (ri < ni) && (ci < ni);
    exact    = '0;
    if (in_range) begin
      case (op_q)
        OP_ADD: exact = EW'(a_rc) + EW'(b_rc);
        OP_SUB: exact = EW'(a_rc) - EW'(b_rc);
        OP_MUL: begin
          for (int unsigned k = 0; k < DIMU; k++) begin
            if (k < ni) begin
              exact = exact
                    + EW'($signed(a_q[(ri * DIMU + k) * WU +: W]))
                    * EW'($signed(b_q[(k * DIMU + ci) * WU +: W]));
            end
          end
        end
        OP_TRN: exact = EW'(a_cr);
        OP_NEG: exact = '0 - EW'(a_rc);
        OP_SCL: exact = EW'(f_q) * EW'(a_rc);
        default: exact = '0;
      endcase
    end
    trunc    = exact[W-1:0];
    // Overflow when the exact value differs from the sign extension of its stored low bits.
    ovf_elem = (exact != {{(EW-W){trunc[W-1]}}, trunc});
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    f_d      = f_q;
    n_d      = n_q;
    r_d      = r_q;
    c_d      = c_q;
    c_flat_d = c_flat_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = A_flat;
          b_d      = B_flat;
          op_d     = opcode;
          f_d      = $signed(f);
          n_d      = (size == 3'd0 || 32'(size) > DIMU) ? NW'(DIMU) : NW'(size);
          r_d      = '0;
          c_d      = '0;
          c_flat_d = '0;
          ovf_d    = 1'b0;
          state_d  = (opcode inside {[4'd1:4'd6]}) ? S_CALC : S_DONE;
        end
      end
      S_CALC: begin
        c_flat_d[(ri * DIMU + ci) * WU +: W] = trunc;
        ovf_d = ovf_q | ovf_elem;
        if (c_q == IW'(DIM - 1)) begin
          c_d = '0;
          if (r_q == IW'(DIM - 1)) begin
            r_d     = '0;
            state_d = S_DONE;
          end else begin
            r_d = r_q + IW'(1);
          end
        end else begin
          c_d = c_q + IW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      f_q      <= '0;
      n_q      <= '0;
      r_q      <= '0;
      c_q      <= '0;
      c_flat_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      f_q      <= f_d;
      n_q      <= n_d;
      r_q      <= r_d;
      c_q      <= c_d;
      c_flat_q <= c_flat_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    busy     = (state_q == S_CALC);
    done     = (state_q == S_DONE);
    overflow = ovf_q;
    C_flat   = c_flat_q;
  end

endmodule

// File: tb/tb_malu_seq.sv
// Directed bench for malu_seq: integer matrix model plus per-cycle compare of busy/done/C/overflow.
module tb_malu_seq;
  localparam int DIM = 5;
  localparam int W   = 8;
  localparam int FW  = 8;
  localparam int NE  = DIM * DIM;

  logic              clk = 1'b0;
  logic              rst, start;
  logic [3:0]        opcode;
  logic [2:0]        size;
  logic [FW-1:0]     f;
  logic [NE*W-1:0]   a_flat, b_flat, c_flat;
  logic              busy, done, overflow;

  always #5 clk = ~clk;

  malu_seq #(.DIM(DIM), .W(W), .FW(FW)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .size(size), .f(f),
    .A_flat(a_flat), .B_flat(b_flat), .busy(busy), .done(done),
    .overflow(overflow), .C_flat(c_flat)
  );

  int ma[DIM][DIM], mb[DIM][DIM];
  int mod_c[DIM][DIM], exp_c[DIM][DIM], zero_c[DIM][DIM];
  bit mod_ovf, exp_ovf, exp_busy, exp_done, exp_cv, chk_en = 1'b0;
  int errors = 0, checks = 0;
  int bad_idx;

  function automatic int wrapw(int v);
    int m;
    m = v & ((1 << W) - 1);
    if (m >= (1 << (W - 1))) m -= (1 << W);
    return m;
  endfunction

  function automatic int dut_el(int r, int c);
    logic signed [W-1:0] t;
    t = c_flat[(r * DIM + c) * W +: W];
    return int'(t);
  endfunction

  // Expected matrix result straight from the arithmetic definition of each opcode.
  task automatic model(input int op, input int sz, input int fv);
    int n, v;
    n = (sz == 0 || sz > DIM) ? DIM : sz;
    mod_ovf = 1'b0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        v = 0;
        if (r < n && c < n) begin
          case (op)
            1: v = ma[r][c] + mb[r][c];
            2: v = ma[r][c] - mb[r][c];
            3: for (int k = 0; k < n; k++) v += ma[r][k] * mb[k][c];
            4: v = ma[c][r];
            5: v = -ma[r][c];
            6: v = fv * ma[r][c];
            default: v = 0;
          endcase
        end
        if (v > (1 << (W - 1)) - 1 || v < -(1 << (W - 1))) mod_ovf = 1'b1;
        mod_c[r][c] = wrapw(v);
      end
    end
  endtask

  task automatic fill(input int av, input int bv);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        ma[r][c] = av;
        mb[r][c] = bv;
      end
  endtask

  task automatic pack();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        a_flat[(r * DIM + c) * W +: W] = W'(ma[r][c]);
        b_flat[(r * DIM + c) * W +: W] = W'(mb[r][c]);
      end
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 one cycle after done.
  task automatic run(input int op, input int sz, input int fv, input bit disturb);
    bit valid;
    valid = (op >= 1 && op <= 6);
    model(op, sz, fv);
    pack();
    opcode = 4'(op);
    size   = 3'(sz);
    f      = FW'(fv);
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (!valid) begin
      exp_busy = 1'b0; exp_done = 1'b1; exp_c = mod_c; exp_ovf = mod_ovf; exp_cv = 1'b1;
    end else begin
      exp_busy = 1'b1; exp_done = 1'b0; exp_cv = 1'b0;
      for (int i = 1; i <= NE; i++) begin
        if (disturb && i == 3) begin
          a_flat = ~a_flat; b_flat = ~b_flat; opcode = 4'd0; size = 3'd1; f = ~f; start = 1'b1;
        end
        if (disturb && i == 4) start = 1'b0;
        @(posedge clk); #1;
        if (i == NE) begin
          exp_busy = 1'b0; exp_done = 1'b1; exp_c = mod_c; exp_ovf = mod_ovf; exp_cv = 1'b1;
          if (disturb) start = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    start    = 1'b0;
    exp_done = 1'b0;
  endtask

  task automatic run_reset_mid();
    fill(2, 2);
    pack();
    opcode = 4'd1; size = 3'd5; f = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_busy = 1'b1; exp_done = 1'b0; exp_cv = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_busy = 1'b0; exp_done = 1'b0; exp_c = zero_c; exp_ovf = 1'b0; exp_cv = 1'b1;
    repeat (NE + 3) begin @(posedge clk); #1; end
  endtask

  task automatic lit_el(input string nm, input int r, input int c, input int v);
    checks++;
    if (dut_el(r, c) !== v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, dut_el(r, c), v);
    end
  endtask

  task automatic lit_ovf(input string nm, input bit v);
    checks++;
    if (overflow !== v) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, overflow, v);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy: got %b expected %b at %0t", busy, exp_busy, $time);
      end
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL done: got %b expected %b at %0t", done, exp_done, $time);
      end
      if (exp_cv) begin
        checks++;
        if (overflow !== exp_ovf) begin
          errors++;
          $display("FAIL overflow: got %b expected %b at %0t", overflow, exp_ovf, $time);
        end
        bad_idx = -1;
        for (int i = NE - 1; i >= 0; i--)
          if (dut_el(i / DIM, i % DIM) !== exp_c[i / DIM][i % DIM]) bad_idx = i;
        checks++;
        if (bad_idx >= 0 || $isunknown(c_flat)) begin
          errors++;
          if (bad_idx < 0) bad_idx = 0;
          $display("FAIL C(%0d,%0d): got %0d expected %0d at %0t", bad_idx / DIM, bad_idx % DIM,
                   dut_el(bad_idx / DIM, bad_idx % DIM), exp_c[bad_idx / DIM][bad_idx % DIM], $time);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; opcode = '0; size = '0; f = '0; a_flat = '0; b_flat = '0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) zero_c[r][c] = 0;
    exp_c = zero_c; exp_ovf = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_cv = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    fill(3, 4);
    run(1, 5, 0, 1'b0);
    lit_el("add_c23", 2, 3, 7);
    lit_ovf("add_ovf", 1'b0);

    fill(9, 9);
    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
    run(3, 2, 0, 1'b0);
    lit_el("mul_c00", 0, 0, 19);
    lit_el("mul_c01", 0, 1, 22);
    lit_el("mul_c10", 1, 0, 43);
    lit_el("mul_c11", 1, 1, 50);
    lit_el("mul_c22", 2, 2, 0);

    fill(1, 0);
    ma[0][0] = 100;
    run(6, 5, -2, 1'b0);
    lit_el("scl_c00", 0, 0, 56);
    lit_el("scl_c44", 4, 4, -2);
    lit_ovf("scl_ovf", 1'b1);

    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) ma[r][c] = 10 * r + c;
    run(4, 3, 0, 1'b0);
    lit_el("trn_c12", 1, 2, 21);
    lit_el("trn_c20", 2, 0, 2);
    lit_el("trn_c33", 3, 3, 0);

    fill(-128, 0);
    run(5, 0, 0, 1'b0);
    lit_el("neg_c00", 0, 0, -128);
    lit_ovf("neg_ovf", 1'b1);

    fill(10, 3);
    ma[4][4] = -100; mb[4][4] = 29;
    run(2, 7, 0, 1'b0);
    lit_el("sub_c44", 4, 4, 127);
    lit_el("sub_c00", 0, 0, 7);
    lit_ovf("sub_ovf", 1'b1);

    run(0, 5, 0, 1'b0);
    lit_el("inv_c00", 0, 0, 0);
    lit_ovf("inv_ovf", 1'b0);
    run(15, 3, 0, 1'b0);

    fill(1, 2);
    run(1, 5, 0, 1'b1);
    lit_el("dist_c33", 3, 3, 3);

    run_reset_mid();
    lit_el("rst_c00", 0, 0, 0);

    fill(5, -6);
    run(1, 5, 0, 1'b0);
    lit_el("post_rst_c04", 0, 4, -1);
    lit_ovf("post_rst_ovf", 1'b0);

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
